gpu_cmd_engine: RTL

Parametrised command processor between the CPU command bus and the GPU text/character RAM. Accepts two-word commands (opcode, parameter) over a valid/ready handshake and translates them into character-RAM write strobes, pointer moves, attribute and cursor settings, and a full-screen clear sweep. Sits in the GPU top level, upstream of the text-mode renderer and font ROM lookup, and owns the write port of the character RAM.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/gpu_cmd_engine_if.sv | 11 +
 rtl/gpu_cmd_ptr.sv | 17 +
 rtl/gpu_cmd_engine.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: opcodes, FSM states and default blank character for the command engine
package gpu_pkg;
  localparam logic [7:0] OP_RESET  = 8'hC0;
  localparam logic [7:0] OP_WRITE  = 8'hC1;
  localparam logic [7:0] OP_DELETE = 8'hC2;
  localparam logic [7:0] OP_SEEK   = 8'hC3;
  localparam logic [7:0] OP_ATTR   = 8'hC4;
  localparam logic [7:0] OP_CLEAR  = 8'hC5;
  localparam logic [7:0] OP_CURSOR = 8'hC6;
  localparam logic [7:0] OP_BURST  = 8'hC7;
  localparam logic [15:0] BLANK_DEFAULT = 16'h0020;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_EXEC,
    S_CLEAR
`ifdef GPU_CMD_BURST_EN
    , S_BURST
`endif
  } state_t;
endpackage

// File: rtl/gpu_cmd_engine_if.sv
// gpu_cmd_engine_if: CPU word handshake plus character RAM write port
interface gpu_cmd_engine_if #(parameter int DATA_W = 16, parameter int ADDR_W = 11);
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_valid;
  logic              cpu_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  modport master (output cpu_data, cpu_valid, input cpu_ready, wr_en, wr_addr, wr_data);
  modport slave  (input cpu_data, cpu_valid, output cpu_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/gpu_cmd_ptr.sv
// gpu_cmd_ptr: address register with load/decrement/increment, wrapping modulo 2**ADDR_W
module gpu_cmd_ptr #(parameter int ADDR_W = 11) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] value
);
  // load has priority over decrement, decrement over increment
  always_ff @(posedge clk or negedge reset)
    if (!reset) value <= '0;
    else if (load) value <= load_val;
    else if (dec) value <= value - ADDR_W'(1);
    else if (inc) value <= value + ADDR_W'(1);
endmodule

// File: rtl/gpu_cmd_engine.sv
// gpu_cmd_engine: two-word command processor driving the character RAM write port (burst opcode C7 enabled by GPU_CMD_BURST_EN)
module gpu_cmd_engine import gpu_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int RAM_DEPTH = 2048,
  parameter int ADDR_W = $clog2(RAM_DEPTH),
  parameter logic [DATA_W-1:0] BLANK = DATA_W'(BLANK_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  gpu_cmd_engine_if.slave   bus,
  output logic [ADDR_W-1:0] pointer,
  output logic [DATA_W-1:0] attr,
  output logic              cursor_en,
  output logic              cursor_blink,
  output logic              busy,
  output logic              err
);
  state_t state;
  logic [7:0] op;
  logic [DATA_W-1:0] param;
  logic [ADDR_W-1:0] sweep;
  logic [ADDR_W-1:0] ptr_val;
  logic exec, accept, clear_done, burst_wr;
  logic ptr_inc, ptr_dec, ptr_load, sweep_inc, sweep_load;
`ifdef GPU_CMD_BURST_EN
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  logic [ADDR_W:0] burst_cnt;
`endif

  // pointer and sweep-counter controls decoded from the current state and latched opcode
  always_comb begin
    exec = state == S_EXEC;
    accept = bus.cpu_valid && bus.cpu_ready;
    clear_done = state == S_CLEAR && bus.wr_addr == {ADDR_W{1'b1}};
`ifdef GPU_CMD_BURST_EN
    burst_wr = state == S_BURST && accept;
`else
    burst_wr = 1'b0;
`endif
    ptr_load = (exec && (op == OP_RESET || op == OP_SEEK)) || clear_done;
    ptr_val = exec && op == OP_SEEK ? param[ADDR_W-1:0] : '0;
    ptr_dec = exec && op == OP_DELETE;
    ptr_inc = (exec && op == OP_WRITE) || burst_wr;
    sweep_load = exec && op == OP_CLEAR;
    sweep_inc = state == S_CLEAR && !clear_done;
  end

  gpu_cmd_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clk(clk), .reset(reset), .inc(ptr_inc), .dec(ptr_dec), .load(ptr_load),
    .load_val(ptr_val), .value(pointer)
  );

  // the sweep starts at 1 because the EXEC cycle already writes address 0
  gpu_cmd_ptr #(.ADDR_W(ADDR_W)) u_sweep (
    .clk(clk), .reset(reset), .inc(sweep_inc), .dec(1'b0), .load(sweep_load),
    .load_val(ADDR_W'(1)), .value(sweep)
  );

  // command FSM with registered handshake, write port and status outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      op <= '0;
      param <= '0;
      bus.cpu_ready <= 1'b1;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      attr <= '0;
      cursor_en <= 1'b0;
      cursor_blink <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
`ifdef GPU_CMD_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        S_IDLE:
          if (accept) begin
            op <= bus.cpu_data[7:0];
            state <= S_PARAM;
          end
        S_PARAM:
          if (accept) begin
            param <= bus.cpu_data;
            state <= S_EXEC;
            bus.cpu_ready <= 1'b0;
            busy <= 1'b1;
          end
        S_EXEC: begin
          state <= S_IDLE;
          bus.cpu_ready <= 1'b1;
          busy <= 1'b0;
          case (op)
            OP_RESET: begin
              attr <= '0;
              cursor_en <= 1'b0;
              cursor_blink <= 1'b0;
              err <= 1'b0;
            end
            OP_WRITE: begin
              bus.wr_en <= 1'b1;
              bus.wr_addr <= pointer;
              bus.wr_data <= param;
            end
            OP_DELETE: begin
              bus.wr_en <= 1'b1;
              bus.wr_addr <= pointer - ADDR_W'(1);
              bus.wr_data <= BLANK;
            end
            OP_SEEK: ;
            OP_ATTR: attr <= param;
            OP_CLEAR: begin
              bus.wr_en <= 1'b1;
              bus.wr_addr <= '0;
              bus.wr_data <= BLANK;
              state <= S_CLEAR;
              bus.cpu_ready <= 1'b0;
              busy <= 1'b1;
            end
            OP_CURSOR: begin
              cursor_en <= param[0];
              cursor_blink <= param[1];
            end
`ifdef GPU_CMD_BURST_EN
            OP_BURST: begin
              burst_cnt <= param[ADDR_W:0];
              if (param[ADDR_W:0] != '0) state <= S_BURST;
            end
`endif
            default: err <= 1'b1;
          endcase
        end
        S_CLEAR:
          if (clear_done) begin
            state <= S_IDLE;
            bus.cpu_ready <= 1'b1;
            busy <= 1'b0;
          end else begin
            bus.wr_en <= 1'b1;
            bus.wr_addr <= sweep;
            bus.wr_data <= BLANK;
          end
`ifdef GPU_CMD_BURST_EN
        S_BURST:
          if (accept) begin
            bus.wr_en <= 1'b1;
            bus.wr_addr <= pointer;
            bus.wr_data <= bus.cpu_data;
            burst_cnt <= burst_cnt - CNT_ONE;
            if (burst_cnt == CNT_ONE) state <= S_IDLE;
          end
`endif
        default: state <= S_IDLE;
      endcase
    end
endmodule
